// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes, FSM states,
// grant identities and the CPU alignment rule.
package dmem_arbiter_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DBG = 1'b1
    } grant_t;

    // Size code 11 is never legal, so it is reported the same way as a misalignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            SIZE_W:  return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and RAM port bundle of the data-memory arbiter.
// slave = arbiter view, master = requesters plus RAM.
interface dmem_arbiter_if #(
    parameter int AW      = 32,
    parameter int DEPTH_W = 10
);
    logic               c_req;
    logic               c_we;
    logic [1:0]         c_size;
    logic               c_sext;
    logic [AW-1:0]      c_addr;
    logic [31:0]        c_wdata;
    logic [31:0]        c_rdata;
    logic               c_ack;
    logic               c_err;

    logic               d_req;
    logic               d_we;
    logic [AW-1:0]      d_addr;
    logic [31:0]        d_wdata;
    logic [31:0]        d_rdata;
    logic               d_ack;

    logic               m_en;
    logic [3:0]         m_we;
    logic [DEPTH_W-1:0] m_addr;
    logic [31:0]        m_wdata;
    logic [31:0]        m_rdata;

    modport slave (
        input  c_req, c_we, c_size, c_sext, c_addr, c_wdata,
        output c_rdata, c_ack, c_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_size, c_sext, c_addr, c_wdata,
        input  c_rdata, c_ack, c_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter_lane_fmt.sv
// Combinational lane logic: store byte-enables and lane replication,
// load byte/half extraction with sign or zero extension (little-endian).
module dmem_arbiter_lane_fmt
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_lo,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [3:0]        st_be,
    output logic [DATA_W-1:0] st_lane,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_lo,
    input  logic              ld_sext,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    function automatic logic [31:0] extend8(input logic [7:0] v, input logic sext);
        logic signed [7:0] sv;
        sv = v;
        return sext ? 32'(sv) : {24'b0, v};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] v, input logic sext);
        logic signed [15:0] sv;
        sv = v;
        return sext ? 32'(sv) : {16'b0, v};
    endfunction

    // Replicating the store data lets the byte enables alone pick the target lane.
    always_comb begin
        st_be   = 4'b1111;
        st_lane = st_wdata;
        case (st_size)
            SIZE_B: begin
                st_be   = 4'b0001 << st_lo;
                st_lane = {4{st_wdata[7:0]}};
            end
            SIZE_H: begin
                st_be   = 4'b0011 << {st_lo[1], 1'b0};
                st_lane = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b  = ld_rdata[{ld_lo, 3'b000} +: 8];
        lane_h  = ld_rdata[{ld_lo[1], 4'b0000} +: 16];
        ld_data = ld_rdata;
        case (ld_size)
            SIZE_B:  ld_data = extend8(lane_b, ld_sext);
            SIZE_H:  ld_data = extend16(lane_h, ld_sext);
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port owner: round-robin between CPU and debug, one access at a time
// over a synchronous RAM (IDLE -> ISSUE -> RESP), misaligned CPU accesses answered with err.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DEPTH_W = 10
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    state_t              state;
    grant_t              last_grant;
    grant_t              grant_q;
    grant_t              sel_grant;
    logic                any_req;
    logic                sel_we;
    logic                sel_sext;
    logic                sel_err;
    logic [1:0]          sel_size;
    logic [1:0]          sel_lo;
    logic [AW-1:0]       sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                we_q;
    logic                sext_q;
    logic                err_q;
    logic [1:0]          size_q;
    logic [1:0]          lo_q;
    logic [3:0]          st_be;
    logic [DATA_W-1:0]   st_lane;
    logic [DATA_W-1:0]   ld_data;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        any_req   = bus.c_req | bus.d_req;
        sel_grant = (bus.c_req && (!bus.d_req || last_grant == GRANT_DBG)) ? GRANT_CPU : GRANT_DBG;
        if (sel_grant == GRANT_CPU) begin
            sel_we    = bus.c_we;
            sel_size  = bus.c_size;
            sel_sext  = bus.c_sext;
            sel_addr  = bus.c_addr;
            sel_lo    = bus.c_addr[1:0];
            sel_wdata = bus.c_wdata;
            sel_err   = misaligned(bus.c_size, bus.c_addr[1:0]);
        end else begin
            sel_we    = bus.d_we;
            sel_size  = SIZE_W;
            sel_sext  = 1'b0;
            sel_addr  = bus.d_addr;
            sel_lo    = 2'b00;
            sel_wdata = bus.d_wdata;
            sel_err   = 1'b0;
        end
    end

    dmem_arbiter_lane_fmt u_lane_fmt (
        .st_size  (sel_size),
        .st_lo    (sel_lo),
        .st_wdata (sel_wdata),
        .st_be    (st_be),
        .st_lane  (st_lane),
        .ld_size  (size_q),
        .ld_lo    (lo_q),
        .ld_sext  (sext_q),
        .ld_rdata (bus.m_rdata),
        .ld_data  (ld_data)
    );

    // Reset clears m_en/m_we asynchronously so an in-flight write never reaches the RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            last_grant  <= GRANT_DBG;
            grant_q     <= GRANT_CPU;
            we_q        <= 1'b0;
            sext_q      <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= SIZE_B;
            lo_q        <= 2'b00;
            bus.c_rdata <= '0;
            bus.c_ack   <= 1'b0;
            bus.c_err   <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.m_en    <= 1'b0;
            bus.m_we    <= 4'b0000;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
        end else begin
            bus.c_ack   <= 1'b0;
            bus.c_err   <= 1'b0;
            bus.c_rdata <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_rdata <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q    <= sel_grant;
                        last_grant <= sel_grant;
                        we_q       <= sel_we;
                        size_q     <= sel_size;
                        sext_q     <= sel_sext;
                        lo_q       <= sel_lo;
                        err_q      <= sel_err;
                        if (sel_err) begin
                            state <= ST_RESP;
                        end else begin
                            state       <= ST_ISSUE;
                            bus.m_en    <= 1'b1;
                            bus.m_we    <= sel_we ? st_be : 4'b0000;
                            bus.m_addr  <= DEPTH_W'(sel_addr >> 2);
                            bus.m_wdata <= st_lane;
                        end
                    end
                end
                ST_ISSUE: begin
                    bus.m_en <= 1'b0;
                    bus.m_we <= 4'b0000;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (grant_q == GRANT_CPU) begin
                        bus.c_ack   <= 1'b1;
                        bus.c_err   <= err_q;
                        bus.c_rdata <= (err_q || we_q) ? '0 : ld_data;
                    end else begin
                        bus.d_ack   <= 1'b1;
                        bus.d_rdata <= we_q ? '0 : ld_data;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked against a
// byte-addressed memory model and a last-winner arbitration model.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DEPTH_W(10)) bus ();
    dmem_arbiter #(.AW(32), .DEPTH_W(10)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Synchronous RAM with byte write enables, read data one cycle after m_en.
    logic [31:0] ram [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.m_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.m_we[i]) ram[bus.m_addr][8*i +: 8] <= bus.m_wdata[8*i +: 8];
            bus.m_rdata <= ram[bus.m_addr];
        end
    end

    // Record every RAM access the arbiter issues.
    int          men_cnt = 0;
    logic [3:0]  mon_we;
    logic [9:0]  mon_addr;
    logic [31:0] mon_wdata;
    always @(negedge clk) begin
        if (bus.m_en) begin
            men_cnt   <= men_cnt + 1;
            mon_we    <= bus.m_we;
            mon_addr  <= bus.m_addr;
            mon_wdata <= bus.m_wdata;
        end
    end

    logic [7:0] ref_mem [0:4095] = '{default: 8'h0};
    bit         last_cpu = 1'b0;
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sext, input logic [31:0] addr);
        int     n;
        int     base;
        longint v;
        n    = nbytes(size);
        base = int'(addr[11:0]) / n * n;
        v    = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + longint'(ref_mem[base + k]);
        if (sext && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [3:0] be);
        int n;
        int base;
        n    = nbytes(size);
        base = int'(addr[11:0]) / n * n;
        be   = 4'b0000;
        for (int k = 0; k < n; k++) begin
            ref_mem[base + k] = wdata[8*k +: 8];
            be[(base + k) % 4] = 1'b1;
        end
    endtask

    task automatic cpu_op(input string tag, input logic we, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        int         lat;
        int         men0;
        logic       bad;
        logic [3:0] be;
        bad  = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        men0 = men_cnt;
        bus.c_req = 1'b1; bus.c_we = we; bus.c_size = size; bus.c_sext = sext;
        bus.c_addr = addr; bus.c_wdata = wdata;
        lat = 0;
        while (bus.c_ack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus.c_rdata;
        chk({tag, "/latency"}, 32'(lat), bad ? 32'd2 : 32'd3);
        chk({tag, "/c_err"}, 32'(bus.c_err), 32'(bad));
        chk({tag, "/d_ack"}, 32'(bus.d_ack), 32'd0);
        last_cpu = 1'b1;
        if (bad) begin
            chk({tag, "/m_en_count"}, 32'(men_cnt - men0), 32'd0);
        end else begin
            chk({tag, "/m_en_count"}, 32'(men_cnt - men0), 32'd1);
            chk({tag, "/m_addr"}, 32'(mon_addr), 32'(addr[11:2]));
            if (we) begin
                ref_store(size, addr, wdata, be);
                chk({tag, "/m_we"}, 32'(mon_we), 32'(be));
            end else begin
                chk({tag, "/m_we"}, 32'(mon_we), 32'd0);
                chk({tag, "/c_rdata"}, rdata, ref_load(size, sext, addr));
            end
        end
        bus.c_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/ack_clear"}, 32'(bus.c_ack), 32'd0);
        chk({tag, "/rdata_clear"}, bus.c_rdata, 32'd0);
    endtask

    task automatic dbg_op(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        int         lat;
        int         men0;
        logic [3:0] be;
        men0 = men_cnt;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        lat = 0;
        while (bus.d_ack !== 1'b1 && lat < 12) begin
            @(posedge clk); #1; lat++;
        end
        rdata = bus.d_rdata;
        chk({tag, "/latency"}, 32'(lat), 32'd3);
        chk({tag, "/c_ack"}, 32'(bus.c_ack), 32'd0);
        chk({tag, "/m_en_count"}, 32'(men_cnt - men0), 32'd1);
        chk({tag, "/m_addr"}, 32'(mon_addr), 32'(addr[11:2]));
        last_cpu = 1'b0;
        if (we) begin
            ref_store(2'b10, addr, wdata, be);
            chk({tag, "/m_we"}, 32'(mon_we), 32'(be));
        end else begin
            chk({tag, "/m_we"}, 32'(mon_we), 32'd0);
            chk({tag, "/d_rdata"}, rdata, ref_load(2'b10, 1'b0, addr));
        end
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk({tag, "/rdata_clear"}, bus.d_rdata, 32'd0);
    endtask

    // Both ports request loads together; the port that did not win last goes first.
    task automatic tie_op(input string tag, input logic [31:0] caddr, input logic [31:0] daddr);
        int  t;
        int  ct;
        int  dt;
        bit  cpu_first;
        cpu_first = !last_cpu;
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_sext = 1'b0; bus.c_addr = caddr;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = daddr;
        t = 0; ct = 0; dt = 0;
        while ((ct == 0 || dt == 0) && t < 20) begin
            @(posedge clk); #1; t++;
            if (bus.c_ack === 1'b1) begin
                ct = t;
                chk({tag, "/c_rdata"}, bus.c_rdata, ref_load(2'b10, 1'b0, caddr));
                bus.c_req = 1'b0;
            end
            if (bus.d_ack === 1'b1) begin
                dt = t;
                chk({tag, "/d_rdata"}, bus.d_rdata, ref_load(2'b10, 1'b0, daddr));
                bus.d_req = 1'b0;
            end
        end
        chk({tag, "/cpu_ack_cycle"}, 32'(ct), cpu_first ? 32'd3 : 32'd6);
        chk({tag, "/dbg_ack_cycle"}, 32'(dt), cpu_first ? 32'd6 : 32'd3);
        bus.c_req = 1'b0; bus.d_req = 1'b0;
        last_cpu = !cpu_first;
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [1:0]  sz;
        rst = 1'b0;
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_size = 2'b00; bus.c_sext = 1'b0;
        bus.c_addr = '0; bus.c_wdata = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset/c_rdata", bus.c_rdata, 32'd0);
        chk("reset/c_ack", 32'(bus.c_ack), 32'd0);
        chk("reset/c_err", 32'(bus.c_err), 32'd0);
        chk("reset/d_rdata", bus.d_rdata, 32'd0);
        chk("reset/d_ack", 32'(bus.d_ack), 32'd0);
        chk("reset/m_en", 32'(bus.m_en), 32'd0);
        chk("reset/m_we", 32'(bus.m_we), 32'd0);
        chk("reset/m_addr", 32'(bus.m_addr), 32'd0);
        chk("reset/m_wdata", bus.m_wdata, 32'd0);
        rst = 1'b1;

        tie_op("tie_from_reset", 32'h0, 32'h4);

        cpu_op("sw_0x8", 1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678, rd);
        chk("sw_0x8/m_we_const", 32'(mon_we), 32'hF);
        chk("sw_0x8/m_addr_const", 32'(mon_addr), 32'd2);
        cpu_op("lb_0x9", 1'b0, 2'b00, 1'b1, 32'h9, 32'h0, rd);
        chk("lb_0x9/const", rd, 32'h00000056);
        cpu_op("lhu_0xA", 1'b0, 2'b01, 1'b0, 32'hA, 32'h0, rd);
        chk("lhu_0xA/const", rd, 32'h00001234);

        cpu_op("sb_0x3", 1'b1, 2'b00, 1'b0, 32'h3, 32'h00000080, rd);
        chk("sb_0x3/m_we_const", 32'(mon_we), 32'h8);
        chk("sb_0x3/m_wdata_const", mon_wdata, 32'h80808080);
        cpu_op("lb_0x3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, rd);
        chk("lb_0x3/const", rd, 32'hFFFFFF80);
        cpu_op("lbu_0x3", 1'b0, 2'b00, 1'b0, 32'h3, 32'h0, rd);
        chk("lbu_0x3/const", rd, 32'h00000080);

        tie_op("tie_after_cpu", 32'h8, 32'h0);

        cpu_op("lh_0x1_misaligned", 1'b0, 2'b01, 1'b1, 32'h1, 32'h0, rd);
        cpu_op("sw_0x6_misaligned", 1'b1, 2'b10, 1'b0, 32'h6, 32'hA5A5A5A5, rd);
        cpu_op("size11_illegal", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd);

        dbg_op("dbg_wr_0x1C", 1'b1, 32'h1C, 32'hCAFEF00D, rd);
        cpu_op("lh_0x1E", 1'b0, 2'b01, 1'b1, 32'h1E, 32'h0, rd);
        chk("lh_0x1E/const", rd, 32'hFFFFCAFE);

        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_size = 2'b10; bus.c_sext = 1'b0; bus.c_addr = 32'h1C;
        for (int t = 1; t <= 9; t++) begin
            @(posedge clk); #1;
            chk($sformatf("back_to_back/ack_t%0d", t), 32'(bus.c_ack), (t % 3 == 0) ? 32'd1 : 32'd0);
            if (t % 3 == 0) chk($sformatf("back_to_back/rdata_t%0d", t), bus.c_rdata, 32'hCAFEF00D);
        end
        bus.c_req = 1'b0;
        last_cpu = 1'b1;
        @(posedge clk); #1;
        chk("back_to_back/ack_clear", 32'(bus.c_ack), 32'd0);

        dbg_op("dbg_wr_0x10", 1'b1, 32'h10, 32'h11223344, rd);
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_size = 2'b10; bus.c_addr = 32'h10; bus.c_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("rst_issue/m_en_before", 32'(bus.m_en), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rst_issue/m_en_after", 32'(bus.m_en), 32'd0);
        chk("rst_issue/m_we_after", 32'(bus.m_we), 32'd0);
        @(posedge clk); #1;
        chk("rst_issue/no_ack", 32'(bus.c_ack), 32'd0);
        bus.c_req = 1'b0;
        rst = 1'b1;
        last_cpu = 1'b0;
        @(posedge clk); #1;
        dbg_op("dbg_rd_0x10", 1'b0, 32'h10, 32'h0, rd);
        chk("dbg_rd_0x10/const", rd, 32'h11223344);

        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
            if (i % 10 == 9) begin
                tie_op($sformatf("rand%0d_tie", i), a & 32'hFFFF_FFFC, a ^ 32'h40);
            end else if ($urandom_range(0, 3) == 0) begin
                dbg_op($sformatf("rand%0d_dbg", i), 1'($urandom_range(0, 1)), a, $urandom, rd);
            end else begin
                sz = 2'($urandom_range(0, 3));
                cpu_op($sformatf("rand%0d_cpu", i), 1'($urandom_range(0, 1)), sz,
                       1'($urandom_range(0, 1)), a, $urandom, rd);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
